// File: rtl/mfp_adc_max10_seq_if.sv
// Register-port and ADC command/response bundle for mfp_adc_max10_seq.
// slave is the sequencer's view; master is the host/ADC side.
interface mfp_adc_max10_seq_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_enable;
    logic [31:0]           read_data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [31:0]           write_data;
    logic                  write_enable;
    logic                  ADC_C_Valid;
    logic                  ADC_C_SOP;
    logic                  ADC_C_EOP;
    logic [4:0]            ADC_C_Channel;
    logic                  ADC_C_Ready;
    logic                  ADC_R_Valid;
    logic                  ADC_R_SOP;
    logic                  ADC_R_EOP;
    logic [4:0]            ADC_R_Channel;
    logic [11:0]           ADC_R_Data;
    logic                  ADC_Trigger;
    logic                  ADC_Interrupt;

    modport master (
        output read_addr, read_enable, write_addr, write_data, write_enable,
        output ADC_C_Ready, ADC_R_Valid, ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data, ADC_Trigger,
        input  read_data, ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel, ADC_Interrupt
    );

    modport slave (
        input  read_addr, read_enable, write_addr, write_data, write_enable,
        input  ADC_C_Ready, ADC_R_Valid, ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data, ADC_Trigger,
        output read_data, ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Channel, ADC_Interrupt
    );
endinterface

// File: rtl/mfp_adc_max10_seq.sv
// Register-mapped MAX10 ADC channel sequencer; command beats held until ADC_C_Ready, no bubbles.
// Define MFP_ADC_AVG_EN to filter stored samples as (3*old+new)/4.
module mfp_adc_max10_seq #(
    parameter int          CH_COUNT   = 7,
    parameter int          DATA_WIDTH = 12,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [39:0] CH_MAP     = 40'({5'd17, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1})
) (
    input logic                CLK,
    input logic                RESETn,
    mfp_adc_max10_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  en_q, en_d, sc_q, sc_d, te_q, te_d;
    logic                  ie_q, ie_d, if_q, if_d, cm_q, cm_d;
    logic [CH_COUNT-1:0]   admsk_q, admsk_d, nd_q, nd_d, pend_q, pend_d;
    logic                  first_q, first_d, trig_q;
    logic [DATA_WIDTH-1:0] cell_q [CH_COUNT];
    logic [DATA_WIDTH-1:0] cell_d [CH_COUNT];

    logic [CH_COUNT-1:0]   cur_oh;
    logic [2:0]            cur_idx;
    logic [5:0]            cur_bit;
    logic                  last_beat, start, resp_eop, trig_rise;
    logic                  wr_adcs, wr_admsk, wr_adst;
    logic                  c_vld, c_sop, c_eop;
    logic [4:0]            c_ch;
    logic [15:0]           r_data_ext;
    logic [DATA_WIDTH-1:0] sample;
    logic [31:0]           rdata;
    logic                  unused_ok;
`ifdef MFP_ADC_AVG_EN
    logic [DATA_WIDTH+1:0] avg_sum;
`endif

    assign r_data_ext = {4'b0, bus.ADC_R_Data};
    assign sample     = r_data_ext[DATA_WIDTH-1:0];
    assign resp_eop   = bus.ADC_R_Valid & bus.ADC_R_EOP;
    assign trig_rise  = bus.ADC_Trigger & ~trig_q;
    assign wr_adcs    = bus.write_enable && (bus.write_addr == ADDR_WIDTH'(0));
    assign wr_admsk   = bus.write_enable && (bus.write_addr == ADDR_WIDTH'(1));
    assign wr_adst    = bus.write_enable && (bus.write_addr == ADDR_WIDTH'(2));
    assign unused_ok  = ^{bus.ADC_R_SOP, bus.write_data, r_data_ext};

    // Lowest pending cell is serviced first.
    always_comb begin
        cur_idx = '0;
        cur_oh  = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                cur_idx = 3'(i);
                cur_oh  = CH_COUNT'(1) << i;
            end
        end
        cur_bit   = 6'(cur_idx) * 6'd5;
        last_beat = ((pend_q & (pend_q - CH_COUNT'(1))) == '0);
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        first_d = first_q;
        start   = 1'b0;
        c_vld   = 1'b0;
        c_sop   = 1'b0;
        c_eop   = 1'b0;
        c_ch    = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (en_q && (admsk_q != '0) && (sc_q || (te_q && trig_rise))) begin
                    state_d = S_RUN;
                    pend_d  = admsk_q;
                    first_d = 1'b1;
                    start   = 1'b1;
                end
            end
            S_RUN: begin
                c_vld = 1'b1;
                c_ch  = CH_MAP[cur_bit +: 5];
                c_sop = first_q;
                c_eop = last_beat | ~en_q;
                if (bus.ADC_C_Ready) begin
                    pend_d  = pend_q & ~cur_oh;
                    first_d = 1'b0;
                    if (c_eop) begin
                        state_d = S_DONE;
                        pend_d  = '0;
                    end
                end
            end
            S_DONE: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (resp_eop) begin
                    if (cm_q && (admsk_q != '0)) begin
                        state_d = S_RUN;
                        pend_d  = admsk_q;
                        first_d = 1'b1;
                        start   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_d    = en_q;
        sc_d    = sc_q;
        te_d    = te_q;
        ie_d    = ie_q;
        if_d    = if_q;
        cm_d    = cm_q;
        admsk_d = admsk_q;
        nd_d    = nd_q;
        cell_d  = cell_q;
`ifdef MFP_ADC_AVG_EN
        avg_sum = '0;
`endif
        if (start) sc_d = 1'b0;
        if (wr_adcs) begin
            en_d = bus.write_data[0];
            sc_d = bus.write_data[1];
            te_d = bus.write_data[2];
            ie_d = bus.write_data[3];
            cm_d = bus.write_data[5];
            if (bus.write_data[4]) if_d = 1'b0;
        end
        if (resp_eop && ie_q) if_d = 1'b1;
        if (wr_admsk) admsk_d = bus.write_data[CH_COUNT-1:0];
        if (wr_adst) nd_d = '0;
        // A store in the same cycle as a read or clear leaves ND set.
        for (int i = 0; i < CH_COUNT; i++) begin
            if (bus.read_enable && (bus.read_addr == ADDR_WIDTH'(3 + i))) nd_d[i] = 1'b0;
            if (bus.ADC_R_Valid && (bus.ADC_R_Channel == CH_MAP[5*i +: 5])) begin
`ifdef MFP_ADC_AVG_EN
                avg_sum   = (DATA_WIDTH+2)'(3) * (DATA_WIDTH+2)'(cell_q[i]) + (DATA_WIDTH+2)'(sample);
                cell_d[i] = nd_q[i] ? avg_sum[DATA_WIDTH+1:2] : sample;
`else
                cell_d[i] = sample;
`endif
                nd_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.read_addr == ADDR_WIDTH'(0)) rdata = {26'b0, cm_q, if_q, ie_q, te_q, sc_q, en_q};
        if (bus.read_addr == ADDR_WIDTH'(1)) rdata = 32'(admsk_q);
        if (bus.read_addr == ADDR_WIDTH'(2)) rdata = 32'(nd_q);
        for (int i = 0; i < CH_COUNT; i++) begin
            if (bus.read_addr == ADDR_WIDTH'(3 + i)) rdata = 32'(cell_q[i]);
        end
    end

    assign bus.read_data     = rdata;
    assign bus.ADC_C_Valid   = c_vld;
    assign bus.ADC_C_SOP     = c_sop;
    assign bus.ADC_C_EOP     = c_eop;
    assign bus.ADC_C_Channel = c_ch;
    assign bus.ADC_Interrupt = if_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            sc_q    <= 1'b0;
            te_q    <= 1'b0;
            ie_q    <= 1'b0;
            if_q    <= 1'b0;
            cm_q    <= 1'b0;
            admsk_q <= '0;
            nd_q    <= '0;
            pend_q  <= '0;
            first_q <= 1'b0;
            trig_q  <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) cell_q[i] <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            sc_q    <= sc_d;
            te_q    <= te_d;
            ie_q    <= ie_d;
            if_q    <= if_d;
            cm_q    <= cm_d;
            admsk_q <= admsk_d;
            nd_q    <= nd_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            trig_q  <= bus.ADC_Trigger;
            cell_q  <= cell_d;
        end
    end
endmodule

// File: tb/tb_mfp_adc_max10_seq.sv
// Directed bench for mfp_adc_max10_seq: register table plus hand-built sequence scenarios.
module tb_mfp_adc_max10_seq;
    logic CLK = 1'b0;
    logic RESETn;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    mfp_adc_max10_seq_if #(.ADDR_WIDTH(4)) bus ();

    mfp_adc_max10_seq #(
        .CH_COUNT(7),
        .DATA_WIDTH(12),
        .ADDR_WIDTH(4)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write_addr   = a;
        bus.write_data   = d;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.read_addr = a;
        #1;
        chk(name, bus.read_data, exp);
    endtask

    task automatic rd_strobe(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.read_addr   = a;
        bus.read_enable = 1'b1;
        #1;
        chk(name, bus.read_data, exp);
        tick();
        bus.read_enable = 1'b0;
    endtask

    task automatic resp(input logic [4:0] ch, input logic [11:0] d, input logic eop);
        bus.ADC_R_Valid   = 1'b1;
        bus.ADC_R_SOP     = 1'b1;
        bus.ADC_R_EOP     = eop;
        bus.ADC_R_Channel = ch;
        bus.ADC_R_Data    = d;
        tick();
        bus.ADC_R_Valid = 1'b0;
        bus.ADC_R_SOP   = 1'b0;
        bus.ADC_R_EOP   = 1'b0;
    endtask

    task automatic wait_vld(input string name, output int waited);
        waited = 0;
        while (!bus.ADC_C_Valid && waited < 10) begin
            tick();
            waited++;
        end
        chk(name, 32'(bus.ADC_C_Valid), 32'h1);
    endtask

    function automatic logic [31:0] beat_now();
        return {24'b0, bus.ADC_C_Valid, bus.ADC_C_SOP, bus.ADC_C_EOP, bus.ADC_C_Channel};
    endfunction

    function automatic logic [31:0] mk(input logic v, input logic s, input logic e, input logic [4:0] ch);
        return {24'b0, v, s, e, ch};
    endfunction

    initial begin
        int w;
        int n;
        logic pend_resp;

        tbl[0]  = {1'b1, 4'd1,  32'h0000_007F, 32'h0};
        tbl[1]  = {1'b0, 4'd1,  32'h0,         32'h7F};
        tbl[2]  = {1'b1, 4'd1,  32'hFFFF_FFFF, 32'h0};
        tbl[3]  = {1'b0, 4'd1,  32'h0,         32'h7F};
        tbl[4]  = {1'b1, 4'd13, 32'h0,         32'h0};
        tbl[5]  = {1'b0, 4'd1,  32'h0,         32'h7F};
        tbl[6]  = {1'b1, 4'd0,  32'h0000_002C, 32'h0};
        tbl[7]  = {1'b0, 4'd0,  32'h0,         32'h2C};
        tbl[8]  = {1'b1, 4'd0,  32'hFFFF_FFC0, 32'h0};
        tbl[9]  = {1'b0, 4'd0,  32'h0,         32'h0};
        tbl[10] = {1'b0, 4'd15, 32'h0,         32'h0};
        tbl[11] = {1'b0, 4'd10, 32'h0,         32'h0};
        tbl[12] = {1'b0, 4'd13, 32'h0,         32'h0};
        tbl[13] = {1'b1, 4'd1,  32'h0,         32'h0};
        tbl[14] = {1'b0, 4'd1,  32'h0,         32'h0};

        RESETn = 1'b0;
        bus.read_addr = '0; bus.read_enable = 1'b0;
        bus.write_addr = '0; bus.write_data = '0; bus.write_enable = 1'b0;
        bus.ADC_C_Ready = 1'b0; bus.ADC_R_Valid = 1'b0; bus.ADC_R_SOP = 1'b0;
        bus.ADC_R_EOP = 1'b0; bus.ADC_R_Channel = '0; bus.ADC_R_Data = '0;
        bus.ADC_Trigger = 1'b0;
        repeat (3) tick();
        peek("rst_adcs", 4'd0, 32'h0);
        peek("rst_admsk", 4'd1, 32'h0);
        tick();
        peek("rst_adst", 4'd2, 32'h0);
        peek("rst_cell0", 4'd3, 32'h0);
        chk("rst_cvld", 32'(bus.ADC_C_Valid), 32'h0);
        chk("rst_irq", 32'(bus.ADC_Interrupt), 32'h0);
        RESETn = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) begin
                wr(tbl[i].addr, tbl[i].wdata);
            end else begin
                peek($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
                tick();
            end
        end

        // Two-channel sequence with Ready held high.
        bus.ADC_C_Ready = 1'b1;
        wr(4'd1, 32'h05);
        wr(4'd0, 32'h03);
        wait_vld("s1_start", w);
        chk("s1_beat1", beat_now(), mk(1, 1, 0, 1));
        tick();
        chk("s1_beat2", beat_now(), mk(1, 0, 1, 3));
        tick();
        chk("s1_done_vld", 32'(bus.ADC_C_Valid), 32'h0);
        peek("s1_sc_clr", 4'd0, 32'h1);
        resp(5'd3, 12'h123, 1'b1);
        peek("s1_adst", 4'd2, 32'h04);
        chk("s1_irq", 32'(bus.ADC_Interrupt), 32'h0);
        tick();
        rd_strobe("s1_cell2", 4'd5, 32'h123);
        peek("s1_nd_clr", 4'd2, 32'h0);

        // New-data flag corner cases.
        resp(5'd9, 12'h777, 1'b0);
        peek("unmatched_ch", 4'd2, 32'h0);
        resp(5'd2, 12'h0AA, 1'b0);
        peek("nd1_set", 4'd2, 32'h02);
        tick();
        wr(4'd2, 32'h0);
        peek("adst_wclr", 4'd2, 32'h0);
        bus.read_addr = 4'd4;
        bus.read_enable = 1'b1;
        resp(5'd2, 12'h0BB, 1'b0);
        bus.read_enable = 1'b0;
        peek("nd_keep", 4'd2, 32'h02);
        tick();
        rd_strobe("cell1_raw", 4'd4, 32'h0BB);
        peek("nd1_rclr", 4'd2, 32'h0);

        // Single masked cell: one beat with SOP and EOP.
        wr(4'd1, 32'h40);
        wr(4'd0, 32'h03);
        wait_vld("s2_start", w);
        chk("s2_beat", beat_now(), mk(1, 1, 1, 17));
        tick();
        chk("s2_done_vld", 32'(bus.ADC_C_Valid), 32'h0);
        resp(5'd17, 12'hABC, 1'b1);
        peek("s2_adst", 4'd2, 32'h40);
        tick();
        rd_strobe("s2_cell6", 4'd9, 32'hABC);
        peek("s2_nd_clr", 4'd2, 32'h0);

        // Backpressure on the second beat.
        wr(4'd1, 32'h07);
        wr(4'd0, 32'h03);
        wait_vld("s3_start", w);
        chk("s3_beat1", beat_now(), mk(1, 1, 0, 1));
        tick();
        bus.ADC_C_Ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("s3_hold%0d", c), beat_now(), mk(1, 0, 0, 2));
            tick();
        end
        bus.ADC_C_Ready = 1'b1;
        chk("s3_beat2", beat_now(), mk(1, 0, 0, 2));
        tick();
        chk("s3_beat3", beat_now(), mk(1, 0, 1, 3));
        tick();
        resp(5'd3, 12'h010, 1'b1);
        chk("s3_idle", 32'(bus.ADC_C_Valid), 32'h0);

        // Continuous mode with interrupts.
        wr(4'd1, 32'h01);
        wr(4'd0, 32'h2B);
        for (int k = 0; k < 3; k++) begin
            wait_vld($sformatf("s4_start%0d", k), w);
            if (k > 0) chk($sformatf("s4_b2b%0d", k), 32'(w), 32'h0);
            chk($sformatf("s4_beat%0d", k), beat_now(), mk(1, 1, 1, 1));
            tick();
            resp(5'd1, 12'(k), 1'b1);
        end
        chk("s4_irq", 32'(bus.ADC_Interrupt), 32'h1);
        peek("s4_adcs", 4'd0, 32'h39);
        wait_vld("s4_cont", w);
        tick();
        bus.write_addr = 4'd0;
        bus.write_data = 32'h10;
        bus.write_enable = 1'b1;
        bus.ADC_R_Valid = 1'b1;
        bus.ADC_R_EOP = 1'b1;
        bus.ADC_R_Channel = 5'd1;
        tick();
        bus.write_enable = 1'b0;
        bus.ADC_R_Valid = 1'b0;
        bus.ADC_R_EOP = 1'b0;
        chk("s4_if_keep_irq", 32'(bus.ADC_Interrupt), 32'h1);
        peek("s4_if_keep", 4'd0, 32'h10);
        repeat (3) tick();
        chk("s4_stopped", 32'(bus.ADC_C_Valid), 32'h0);
        wr(4'd0, 32'h10);
        peek("s4_if_clr", 4'd0, 32'h0);
        chk("s4_irq_clr", 32'(bus.ADC_Interrupt), 32'h0);

        // Trigger held high for ten cycles starts one sequence only.
        wr(4'd0, 32'h05);
        bus.ADC_Trigger = 1'b1;
        pend_resp = 1'b0;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) bus.ADC_Trigger = 1'b0;
            bus.ADC_R_Valid = pend_resp;
            bus.ADC_R_EOP = pend_resp;
            bus.ADC_R_Channel = 5'd1;
            #1;
            pend_resp = bus.ADC_C_Valid & bus.ADC_C_EOP;
            if (bus.ADC_C_Valid && bus.ADC_C_SOP) n++;
            tick();
        end
        bus.ADC_R_Valid = 1'b0;
        bus.ADC_R_EOP = 1'b0;
        chk("s5_one_seq", 32'(n), 32'h1);
        wr(4'd0, 32'h0);

        // Sample storage: raw on first store, filtered afterwards when averaging is built in.
        wr(4'd2, 32'h0);
        resp(5'd1, 12'h400, 1'b0);
        peek("s6_first", 4'd3, 32'h400);
        tick();
        resp(5'd1, 12'h800, 1'b0);
`ifdef MFP_ADC_AVG_EN
        peek("s6_avg", 4'd3, 32'h500);
`else
        peek("s6_raw", 4'd3, 32'h800);
`endif
        tick();

        // Reset in the middle of a held beat.
        bus.ADC_C_Ready = 1'b0;
        wr(4'd0, 32'h03);
        wait_vld("s7_start", w);
        tick();
        chk("s7_held", 32'(bus.ADC_C_Valid), 32'h1);
        RESETn = 1'b0;
        tick();
        chk("s7_abort", 32'(bus.ADC_C_Valid), 32'h0);
        peek("s7_adcs", 4'd0, 32'h0);
        peek("s7_admsk", 4'd1, 32'h0);
        RESETn = 1'b1;
        bus.ADC_C_Ready = 1'b1;
        repeat (3) tick();
        chk("s7_no_resume", 32'(bus.ADC_C_Valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mfp_adc_max10_seq.md
MFP_ADC_MAX10_SEQ -- requirements
Module: mfp_adc_max10_seq

Interface
REQ-001 SHALL have parameter CH_COUNT, default 7, number of sequenced channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, ADC sample width (1..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, register word-address width.
REQ-004 SHALL have parameter CH_MAP, default {5'd17,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1}, packed 5-bit hardware channel per cell i at bits [5i+4:5i].
REQ-005 SHALL have ports, in order:
 CLK  in  1  clock, all logic on rising edge
 RESETn  in  1  reset, synchronous, active-low
 read_addr  in  ADDR_WIDTH  register read address
 read_enable  in  1  read strobe, side effects only
 read_data  out  32  combinational read data
 write_addr  in  ADDR_WIDTH  register write address
 write_data  in  32  write data
 write_enable  in  1  write strobe
 ADC_C_Valid/SOP/EOP  out  1 each  command beat
 ADC_C_Channel  out  5  command channel
 ADC_C_Ready  in  1  command accepted
 ADC_R_Valid/SOP/EOP  in  1 each  response beat
 ADC_R_Channel  in  5  response channel
 ADC_R_Data  in  12  response sample
 ADC_Trigger  in  1  external trigger
 ADC_Interrupt  out  1  equals ADCS.IF
Function
REQ-006 SHALL map registers: 0 ADCS, 1 ADMSK[CH_COUNT-1:0], 2 ADST (new-data flags ND[CH_COUNT-1:0]), 3+i data cell i zero-extended; unmapped reads return 0, unmapped writes ignored.
REQ-007 SHALL define ADCS bits: 0 EN, 1 SC, 2 TE, 3 IE, 4 IF, 5 CM (continuous); other bits read 0.
REQ-008 SHALL make SC self-clearing: cleared the cycle after a sequence starts.
REQ-009 SHALL clear IF on write of 1 to bit 4; IF set by ADC_R_Valid&ADC_R_EOP&IE wins over simultaneous clear.
REQ-010 SHALL start a sequence from IDLE when EN & (ADMSK!=0) & (SC | (TE & trigger rising edge)); trigger edge detected against previous-cycle registered ADC_Trigger.
REQ-011 SHALL snapshot ADMSK into a pending vector at start; ADMSK writes mid-sequence affect only the next sequence.
REQ-012 SHALL use FSM IDLE -> RUN -> DONE; IDLE: Valid=0, Channel=0.
REQ-013 SHALL in RUN drive Valid=1, Channel=CH_MAP[lowest pending cell], SOP=1 on first beat only, EOP=1 when it is the last pending cell or EN=0; all held stable until ADC_C_Ready.
REQ-014 SHALL on Ready in RUN clear that pending bit; go to DONE if EOP was 1, else stay in RUN next cell with zero bubble cycles.
REQ-015 SHALL emit one beat with SOP=EOP=1 when exactly one cell is masked.
REQ-016 SHALL leave DONE on the first ADC_R_Valid&ADC_R_EOP: to RUN (new snapshot) if EN&CM&(ADMSK!=0), else IDLE; EN=0 in DONE -> IDLE next cycle.
REQ-017 SHALL store ADC_R_Data[DATA_WIDTH-1:0] in cell i and set ND[i] when ADC_R_Valid and ADC_R_Channel==CH_MAP[i]; unmatched channels ignored.
REQ-018 SHALL clear ND[i] on read_enable of data cell i; simultaneous store keeps ND[i]=1.
REQ-019 SHALL clear all ND on write of any value to ADST.
Reset
REQ-020 SHALL, while RESETn=0 at a clock edge, set state IDLE, all registers, ND, pending, trigger history to 0; all outputs 0.
REQ-021 SHALL abort any sequence on reset without completing the held beat.
Configuration
REQ-022 SHALL, with macro MFP_ADC_AVG_EN defined, store cell value (3*old+new)>>2 computed in DATA_WIDTH+2 bits, except the first store after ND cleared loads raw sample; without it, raw sample always stored.
Verification
REQ-023 SHALL cover ADMSK=0b0000101, ADCS=0x3, Ready=1 -> beats ch1 SOP, ch3 EOP, SC reads 0 afterwards.
REQ-024 SHALL cover ADMSK=0b1000000 -> single beat ch17 SOP=EOP=1; response 0xABC -> cell 6 reads 0xABC, ADST bit6=1, cleared by read.
REQ-025 SHALL cover Ready low 5 cycles on beat 2 -> Valid/Channel/SOP/EOP stable all 5 cycles.
REQ-026 SHALL cover CM=1, IE=1, three response EOPs -> three back-to-back sequences, IF=1; write 0x10 with coincident EOP -> IF stays 1.
REQ-027 SHALL cover TE=1, ADC_Trigger held high 10 cycles -> exactly one sequence.
REQ-028 SHALL cover MFP_ADC_AVG_EN, samples 0x400 then 0x800 -> cell reads 0x400 then 0x500.
